// File: rtl/fft_output_ctrl_if.sv
// Bundle of FFT-core input, buffer write/read port and line-consumer handshake
// signals owned by fft_output_ctrl. The master modport is the controller's view.
interface fft_output_ctrl_if #(
    parameter int SIZE       = 16,
    parameter int SAMPLES    = 2048,
    parameter int INPUT_SIZE = 512
);
    localparam int LINES = SAMPLES * SIZE / INPUT_SIZE;
    localparam int SW    = $clog2(SAMPLES);
    localparam int LW    = $clog2(LINES);

    logic            fft_valid;
    logic [SIZE-1:0] fft_data;
    logic            fft_ready;
    logic            buf_wr_en;
    logic [SW-1:0]   buf_input_index;
    logic [SIZE-1:0] buf_data_in;
    logic [LW-1:0]   buf_output_index;
    logic            line_valid;
    logic            line_ready;
    logic            line_last;

    modport master (
        input  fft_valid, fft_data, line_ready,
        output fft_ready, buf_wr_en, buf_input_index, buf_data_in,
               buf_output_index, line_valid, line_last
    );

    modport slave (
        output fft_valid, fft_data, line_ready,
        input  fft_ready, buf_wr_en, buf_input_index, buf_data_in,
               buf_output_index, line_valid, line_last
    );
endinterface

// File: rtl/fft_output_ctrl.sv
// FFT output buffer sequencer: fills SAMPLES samples from the core, then drains LINES wide lines.
// Optional macro BIT_REVERSE_EN stores samples at bit-reversed indices (natural-order output).
module fft_output_ctrl #(
    parameter int SIZE       = 16,
    parameter int SAMPLES    = 2048,
    parameter int INPUT_SIZE = 512
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    fft_output_ctrl_if.master  bus
);
    localparam int LINES = SAMPLES * SIZE / INPUT_SIZE;
    localparam int SW    = $clog2(SAMPLES);
    localparam int LW    = $clog2(LINES);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t        state_reg, state_next;
    logic [SW-1:0] sample_cnt_reg, sample_cnt_next;
    logic [LW-1:0] line_cnt_reg, line_cnt_next;
    logic          busy_reg;
    logic          done_reg, done_next;
    logic          fill_ready;
    logic          drain_valid;
    logic          accept;
    logic [SW-1:0] wr_index;

`ifdef BIT_REVERSE_EN
    generate
        for (genvar gi = 0; gi < SW; gi++) begin : g_rev
            assign wr_index[gi] = sample_cnt_reg[SW-1-gi];
        end
    endgenerate
`else
    assign wr_index = sample_cnt_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            sample_cnt_reg <= '0;
            line_cnt_reg   <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sample_cnt_reg <= sample_cnt_next;
            line_cnt_reg   <= line_cnt_next;
            // Registered from the next state so busy tracks the state register exactly.
            busy_reg       <= (state_next != IDLE);
            done_reg       <= done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        sample_cnt_next = sample_cnt_reg;
        line_cnt_next   = line_cnt_reg;
        done_next       = 1'b0;
        fill_ready      = 1'b0;
        drain_valid     = 1'b0;
        accept          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start && !flush) begin
                    state_next      = FILL;
                    sample_cnt_next = '0;
                    line_cnt_next   = '0;
                end
            end
            FILL: begin
                if (flush) begin
                    state_next      = IDLE;
                    sample_cnt_next = '0;
                    line_cnt_next   = '0;
                end else begin
                    fill_ready = 1'b1;
                    accept     = bus.fft_valid;
                    if (accept) begin
                        sample_cnt_next = sample_cnt_reg + SW'(1);
                        if (sample_cnt_reg == SW'(SAMPLES - 1)) begin
                            state_next = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (flush) begin
                    state_next      = IDLE;
                    sample_cnt_next = '0;
                    line_cnt_next   = '0;
                end else begin
                    drain_valid = 1'b1;
                    if (bus.line_ready) begin
                        line_cnt_next = line_cnt_reg + LW'(1);
                        if (line_cnt_reg == LW'(LINES - 1)) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // fft_ready depends only on state and flush, never on line_ready.
    assign bus.fft_ready        = fill_ready;
    assign bus.buf_wr_en        = accept;
    assign bus.buf_input_index  = wr_index;
    assign bus.buf_data_in      = accept ? bus.fft_data : '0;
    assign bus.buf_output_index = line_cnt_reg;
    assign bus.line_valid       = drain_valid;
    assign bus.line_last        = (state_reg == DRAIN) && (line_cnt_reg == LW'(LINES - 1));
    assign busy                 = busy_reg;
    assign done                 = done_reg;
endmodule
